fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The module SHALL have one parameter: DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 The module SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 The module SHALL have port: reset  input  1  synchronous, active-low reset; reset==0 at a rising clk edge resets the block.
REQ-004 The module SHALL have port: f_valid  input  1  fetch slot holds a valid {f_pc, f_instr} pair.
REQ-005 The module SHALL have port: f_pc  input  32  PC of fetched instruction.
REQ-006 The module SHALL have port: f_instr  input  32  fetched instruction word.
REQ-007 The module SHALL have port: f_stall  output  1  queue full; drives PC hold enable (1 = PC holds).
REQ-008 The module SHALL have port: flush  input  1  branch/jump redirect; discard all queued entries.
REQ-009 The module SHALL have port: d_ready  input  1  decode stage accepts head entry this cycle.
REQ-010 The module SHALL have port: d_valid  output  1  head entry valid.
REQ-011 The module SHALL have port: d_pc  output  32  PC of head entry.
REQ-012 The module SHALL have port: d_instr  output  32  instruction of head entry.
REQ-013 The module SHALL have port: count  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-014 The module SHALL be a FIFO of DEPTH entries, each {pc[31:0], instr[31:0]}, preserving insertion order.
REQ-015 The module SHALL perform a push when f_valid==1, f_stall==0 and flush==0; the pair is written at wr_ptr and wr_ptr advances by 1 modulo DEPTH.
REQ-016 The module SHALL perform a pop when d_valid==1, d_ready==1 and flush==0; rd_ptr advances by 1 modulo DEPTH.
REQ-017 The module SHALL drive f_stall = (count==DEPTH) from registered state only; there is no same-cycle pop-through when full.
REQ-018 The module SHALL ignore f_valid while f_stall==1; no entry is written and upstream holds its PC.
REQ-019 The module SHALL drive d_valid = (count!=0), with d_pc/d_instr combinationally from the entry at rd_ptr.
REQ-020 The module SHALL drive d_pc = 32'h0000_0000 and d_instr = 32'h0000_0000 (NOP) whenever count==0.
REQ-021 The module SHALL give one-cycle latency: a push at edge N is visible on d_* after edge N; there is no empty-queue bypass.
REQ-022 The module SHALL update count: push only +1; pop only -1; push and pop together unchanged; neither unchanged.
REQ-023 The module SHALL, when push and pop coincide at 0<count<DEPTH, write the new entry and present the next-oldest entry after the edge.
REQ-024 The module SHALL treat flush==1 as priority over push and pop: at that edge count, rd_ptr and wr_ptr become 0 and the concurrent fetch pair is not stored.
REQ-025 The module SHALL keep count within 0..DEPTH at all times; no pop occurs when empty, no push when full.

Reset
REQ-026 The module SHALL, on reset==0 at a rising edge, set count=0, rd_ptr=0 and wr_ptr=0, giving d_valid=0, f_stall=0, d_pc=0 and d_instr=0.
REQ-027 The module SHALL give reset priority over flush, push and pop, including mid-operation with a non-empty queue.
REQ-028 The module need not clear entry storage on reset; stored data is unobservable while count==0.

Verification
REQ-029 The bench SHALL cover reset: hold reset=0 for one edge with f_valid=1 -> count=0, d_valid=0, f_stall=0, d_instr=0.
REQ-030 The bench SHALL cover fill and drain: push pc 0x3000..0x300C (instr 0xA0..0xA3), d_ready=0 -> count=4, f_stall=1; a push at pc 0x3010 is ignored; then d_ready=1 -> d_pc 0x3000,0x3004,0x3008,0x300C on successive cycles, then d_valid=0.
REQ-031 The bench SHALL cover simultaneous push/pop: at count=2 with f_valid=1 and d_ready=1 for 3 cycles -> count stays 2, output order preserved.
REQ-032 The bench SHALL cover flush: at count=3 with f_valid=1, d_ready=1, flush=1 -> after edge count=0, d_valid=0, flushed pc absent from later output.
REQ-033 The bench SHALL cover wrap-around: 10 push/pop cycles with pc 0x3000+4k -> d_pc sequence 0x3000..0x3024 in order, no loss or duplication.
REQ-034 The bench SHALL cover reset mid-operation: at count=3, reset=0 for one edge -> count=0, d_valid=0; the next push appears alone at the head.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bundle: fetch push side, decode pop side, flush and occupancy.
// slave is the queue itself; master is the surrounding pipeline (or a bench).
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            f_valid;
  logic [31:0]     f_pc;
  logic [31:0]     f_instr;
  logic            f_stall;
  logic            flush;
  logic            d_ready;
  logic            d_valid;
  logic [31:0]     d_pc;
  logic [31:0]     d_instr;
  logic [CntW-1:0] count;

  modport master (
    output f_valid, f_pc, f_instr, flush, d_ready,
    input  f_stall, d_valid, d_pc, d_instr, count
  );

  modport slave (
    input  f_valid, f_pc, f_instr, flush, d_ready,
    output f_stall, d_valid, d_pc, d_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: DEPTH-entry FIFO of {pc, instr} between fetch and decode.
// The stall and head outputs come from registered state only; flush empties the queue.
module fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.slave fq
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     r_pc_mem    [DEPTH];
  logic [31:0]     r_instr_mem [DEPTH];
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [CntW-1:0] r_count;

  logic w_full;
  logic w_nonempty;
  logic w_push;
  logic w_pop;

  assign w_full     = (r_count == CntW'(DEPTH));
  assign w_nonempty = (r_count != '0);
  // No pop-through when full: a full queue refuses the push even if decode pops.
  assign w_push     = fq.f_valid & ~w_full & ~fq.flush;
  assign w_pop      = w_nonempty & fq.d_ready & ~fq.flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (fq.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  // Storage is not reset; contents are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_pc_mem[r_wr_ptr]    <= fq.f_pc;
      r_instr_mem[r_wr_ptr] <= fq.f_instr;
    end
  end

  always_comb begin
    fq.f_stall = w_full;
    fq.d_valid = w_nonempty;
    fq.count   = r_count;
    fq.d_pc    = 32'h0000_0000;
    fq.d_instr = 32'h0000_0000;
    if (w_nonempty) begin
      fq.d_pc    = r_pc_mem[r_rd_ptr];
      fq.d_instr = r_instr_mem[r_rd_ptr];
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/drain, push+pop, flush, wrap, mid-run reset.
module tb_fetch_queue;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  fetch_queue_if #(.DEPTH(4)) fq ();

  fetch_queue #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    fq.f_valid = v;
    fq.f_pc    = pc;
    fq.f_instr = ins;
    fq.d_ready = rdy;
    fq.flush   = fl;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b0;
    drive(1'b1, 32'h0000_9999, 32'h0000_0099, 1'b0, 1'b0);
    #2;

    // Reset with f_valid asserted
    step();
    check("rst_count", 32'(fq.count), 32'd0);
    check("rst_dvalid", 32'(fq.d_valid), 32'd0);
    check("rst_stall", 32'(fq.f_stall), 32'd0);
    check("rst_dinstr", fq.d_instr, 32'h0);
    check("rst_dpc", fq.d_pc, 32'h0);
    reset = 1'b1;

    // Fill with decode stalled
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h3000 + 32'(4 * k), 32'hA0 + 32'(k), 1'b0, 1'b0);
      step();
      if (k == 0) begin
        check("fill_first_dvalid", 32'(fq.d_valid), 32'd1);
        check("fill_first_dpc", fq.d_pc, 32'h3000);
      end
    end
    check("fill_count", 32'(fq.count), 32'd4);
    check("fill_stall", 32'(fq.f_stall), 32'd1);
    drive(1'b1, 32'h3010, 32'hA4, 1'b0, 1'b0);
    step();
    check("full_ignore_count", 32'(fq.count), 32'd4);
    check("full_ignore_head", fq.d_pc, 32'h3000);

    // Drain
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_pc%0d", k), fq.d_pc, 32'h3000 + 32'(4 * k));
      check($sformatf("drain_in%0d", k), fq.d_instr, 32'hA0 + 32'(k));
      step();
    end
    check("drain_dvalid", 32'(fq.d_valid), 32'd0);
    check("drain_dpc_nop", fq.d_pc, 32'h0);
    check("drain_count", 32'(fq.count), 32'd0);

    // Simultaneous push/pop at count=2
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h4000 + 32'(4 * k), 32'hB0 + 32'(k), 1'b0, 1'b0);
      step();
    end
    check("pp_count_pre", 32'(fq.count), 32'd2);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h4008 + 32'(4 * k), 32'hB2 + 32'(k), 1'b1, 1'b0);
      check($sformatf("pp_head%0d", k), fq.d_pc, 32'h4000 + 32'(4 * k));
      step();
      check($sformatf("pp_count%0d", k), 32'(fq.count), 32'd2);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("pp_tail0", fq.d_pc, 32'h400C);
    check("pp_tail0_in", fq.d_instr, 32'hB3);
    step();
    check("pp_tail1", fq.d_pc, 32'h4010);
    step();
    check("pp_empty", 32'(fq.d_valid), 32'd0);

    // Flush at count=3 with concurrent push and pop
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h5000 + 32'(4 * k), 32'hC0 + 32'(k), 1'b0, 1'b0);
      step();
    end
    check("fl_count_pre", 32'(fq.count), 32'd3);
    drive(1'b1, 32'h6000, 32'hD0, 1'b1, 1'b1);
    step();
    check("fl_count", 32'(fq.count), 32'd0);
    check("fl_dvalid", 32'(fq.d_valid), 32'd0);
    drive(1'b1, 32'h6004, 32'hD1, 1'b0, 1'b0);
    step();
    check("fl_after_count", 32'(fq.count), 32'd1);
    check("fl_after_head", fq.d_pc, 32'h6004);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    check("fl_after_empty", 32'(fq.d_valid), 32'd0);

    // Wrap-around: 10 push/pop cycles
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h3000 + 32'(4 * k), 32'hE0 + 32'(k), 1'b1, 1'b0);
      if (k > 0) check($sformatf("wrap_pc%0d", k - 1), fq.d_pc, 32'h3000 + 32'(4 * (k - 1)));
      step();
      check($sformatf("wrap_cnt%0d", k), 32'(fq.count), 32'd1);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("wrap_pc9", fq.d_pc, 32'h3024);
    step();
    check("wrap_empty", 32'(fq.d_valid), 32'd0);

    // Reset mid-operation at count=3
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h7000 + 32'(4 * k), 32'hF0 + 32'(k), 1'b0, 1'b0);
      step();
    end
    check("mr_count_pre", 32'(fq.count), 32'd3);
    drive(1'b1, 32'h7FFC, 32'hFF, 1'b1, 1'b1);
    reset = 1'b0;
    step();
    check("mr_count", 32'(fq.count), 32'd0);
    check("mr_dvalid", 32'(fq.d_valid), 32'd0);
    reset = 1'b1;
    drive(1'b1, 32'h7100, 32'hF8, 1'b0, 1'b0);
    step();
    check("mr_head", fq.d_pc, 32'h7100);
    check("mr_head_count", 32'(fq.count), 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    check("mr_alone", 32'(fq.d_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule
